// File: rtl/icache_refill_wb.sv
// icache_refill_wb: fetches one instruction cache line over Wishbone B3, critical word first, and streams it to the cache
// Ports: refill_req_i/refill_adr_i start a line fill; wradr_o/wrdat_o/we_o stream each fetched word to the cache;
//        imem_err_o pulses on a bus error; busy_o is high whenever the engine is not idle;
//        wbm_* is the Wishbone B3 read master (incrementing wrap bursts, or classic single reads).
module icache_refill_wb #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5,
    parameter bit BURST_ENABLE              = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            imem_err_o,
    output logic                            busy_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    input  logic                            wbm_rty_i
);
    localparam int AW = OPTION_OPERAND_WIDTH;
    localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int PW = BW - 2;
    // line holds 2^PW words, so the last beat index is all ones
    localparam logic [PW-1:0] LAST = '1;
    localparam logic [1:0] BTE = BW == 5 ? 2'b10 : 2'b01;
    typedef enum logic [1:0] {IDLE, BURST, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic [AW-1:BW] base;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cnt;
    logic beat;
    // a retry is simply a beat without ack; the address bits below a word are don't-care
    logic unused_bits;
    assign unused_bits = ^{refill_adr_i[1:0], wbm_rty_i};
    // error wins over a simultaneous ack
    assign beat = state == BURST && wbm_ack_i && !wbm_err_i;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = refill_req_i && !imem_err_o ? BURST : IDLE;
            BURST:   state_nxt = wbm_err_i ? IDLE : !wbm_ack_i ? BURST : cnt == LAST ? DONE : BURST_ENABLE ? BURST : WAIT;
            WAIT:    state_nxt = BURST;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            ptr        <= '0;
            cnt        <= '0;
            wradr_o    <= '0;
            wrdat_o    <= '0;
            we_o       <= 1'b0;
            imem_err_o <= 1'b0;
        end else begin
            we_o       <= beat;
            imem_err_o <= state == BURST && wbm_err_i;
            if (state == IDLE && state_nxt == BURST) begin
                base <= refill_adr_i[AW-1:BW];
                ptr  <= refill_adr_i[BW-1:2];
                cnt  <= '0;
            end
            if (beat) begin
                wradr_o <= wbm_adr_o;
                wrdat_o <= wbm_dat_i;
                ptr     <= ptr + 1'b1;
                cnt     <= cnt + 1'b1;
            end
        end
    end
    assign busy_o    = state != IDLE;
    assign wbm_cyc_o = state == BURST;
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hf;
    assign wbm_adr_o = {base, ptr, 2'b00};
    assign wbm_cti_o = !wbm_cyc_o || !BURST_ENABLE ? 3'b000 : cnt == LAST ? 3'b111 : 3'b010;
    assign wbm_bte_o = wbm_cyc_o && BURST_ENABLE ? BTE : 2'b00;
endmodule

// File: tb/tb_icache_refill_wb.sv
// tb_icache_refill_wb: directed scoreboard bench for icache_refill_wb (8-word burst and 4-word classic variants)
module tb_icache_refill_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t sb0[$];
    wr_t sb1[$];
    wr_t w0;
    wr_t w1;
    int compared = 0;
    int mismatched = 0;
    logic        req0 = 1'b0, ack0 = 1'b0, err0 = 1'b0, rty0 = 1'b0;
    logic [31:0] adr0 = '0, dat0 = '0;
    logic [31:0] wradr0, wrdat0, wbadr0;
    logic        we0, ierr0, busy0, cyc0, stb0, wbwe0;
    logic [3:0]  sel0;
    logic [2:0]  cti0;
    logic [1:0]  bte0;
    logic        req1 = 1'b0, ack1 = 1'b0, err1 = 1'b0, rty1 = 1'b0;
    logic [31:0] adr1 = '0, dat1 = '0;
    logic [31:0] wradr1, wrdat1, wbadr1;
    logic        we1, ierr1, busy1, cyc1, stb1, wbwe1;
    logic [3:0]  sel1;
    logic [2:0]  cti1;
    logic [1:0]  bte1;
    icache_refill_wb u0 (
        .clk(clk), .rst(rst), .refill_req_i(req0), .refill_adr_i(adr0),
        .wradr_o(wradr0), .wrdat_o(wrdat0), .we_o(we0), .imem_err_o(ierr0), .busy_o(busy0),
        .wbm_adr_o(wbadr0), .wbm_cyc_o(cyc0), .wbm_stb_o(stb0), .wbm_we_o(wbwe0), .wbm_sel_o(sel0),
        .wbm_cti_o(cti0), .wbm_bte_o(bte0), .wbm_dat_i(dat0), .wbm_ack_i(ack0), .wbm_err_i(err0), .wbm_rty_i(rty0)
    );
    icache_refill_wb #(.OPTION_ICACHE_BLOCK_WIDTH(4), .BURST_ENABLE(1'b0)) u1 (
        .clk(clk), .rst(rst), .refill_req_i(req1), .refill_adr_i(adr1),
        .wradr_o(wradr1), .wrdat_o(wrdat1), .we_o(we1), .imem_err_o(ierr1), .busy_o(busy1),
        .wbm_adr_o(wbadr1), .wbm_cyc_o(cyc1), .wbm_stb_o(stb1), .wbm_we_o(wbwe1), .wbm_sel_o(sel1),
        .wbm_cti_o(cti1), .wbm_bte_o(bte1), .wbm_dat_i(dat1), .wbm_ack_i(ack1), .wbm_err_i(err1), .wbm_rty_i(rty1)
    );
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // every refill write must match the oldest word the bench acked
    always @(negedge clk) begin
        if (we0) begin
            if (sb0.size() == 0) chk("we0_extra", 64'(we0), 64'd0);
            else begin
                w0 = sb0.pop_front();
                chk("wradr0", 64'(wradr0), 64'(w0.a));
                chk("wrdat0", 64'(wrdat0), 64'(w0.d));
            end
        end
        if (we1) begin
            if (sb1.size() == 0) chk("we1_extra", 64'(we1), 64'd0);
            else begin
                w1 = sb1.pop_front();
                chk("wradr1", 64'(wradr1), 64'(w1.a));
                chk("wrdat1", 64'(wrdat1), 64'(w1.d));
            end
        end
    end
    task automatic chk_reset0(input string tag);
        chk({tag, "_cyc"}, 64'(cyc0), 64'd0);
        chk({tag, "_stb"}, 64'(stb0), 64'd0);
        chk({tag, "_we"}, 64'(we0), 64'd0);
        chk({tag, "_ierr"}, 64'(ierr0), 64'd0);
        chk({tag, "_busy"}, 64'(busy0), 64'd0);
        chk({tag, "_sel"}, 64'(sel0), 64'hf);
        chk({tag, "_cti"}, 64'(cti0), 64'd0);
        chk({tag, "_bte"}, 64'(bte0), 64'd0);
        chk({tag, "_adr"}, 64'(wbadr0), 64'd0);
        chk({tag, "_wradr"}, 64'(wradr0), 64'd0);
        chk({tag, "_wrdat"}, 64'(wrdat0), 64'd0);
        chk({tag, "_wbwe"}, 64'(wbwe0), 64'd0);
    endtask
    // one 8-word refill on u0; gap = idle cycles before each ack, -1 disables rty/err/rst injection
    task automatic run(input logic [31:0] a, input int gap, input int rty_at, input int err_at, input int rst_at, input bit hold);
        logic [31:0] e;
        req0 = 1'b1;
        adr0 = a;
        @(negedge clk);
        req0 = 1'b0;
        chk("start_cyc", 64'(cyc0), 64'd1);
        chk("start_busy", 64'(busy0), 64'd1);
        for (int i = 0; i < 8; i++) begin
            e = (a & ~32'h1f) | ((((a >> 2) + 32'(i)) & 32'h7) << 2);
            repeat (gap) @(negedge clk);
            if (i == rty_at) begin
                rty0 = 1'b1;
                @(negedge clk);
                rty0 = 1'b0;
                chk("rty_stb", 64'(stb0), 64'd1);
            end
            chk("adr", 64'(wbadr0), 64'(e));
            chk("cti", 64'(cti0), i == 7 ? 64'h7 : 64'h2);
            chk("bte", 64'(bte0), 64'h2);
            dat0 = mem(e);
            ack0 = 1'b1;
            if (i == err_at) begin
                err0 = 1'b1;
                @(negedge clk);
                ack0 = 1'b0;
                err0 = 1'b0;
                chk("err_cyc", 64'(cyc0), 64'd0);
                chk("err_pulse", 64'(ierr0), 64'd1);
                chk("err_busy", 64'(busy0), 64'd0);
                chk("err_we", 64'(we0), 64'd0);
                req0 = 1'b1;
                adr0 = a + 32'h20;
                @(negedge clk);
                req0 = 1'b0;
                chk("err_pulse_end", 64'(ierr0), 64'd0);
                chk("err_req_ignored", 64'(busy0), 64'd0);
                chk("err_sb_empty", 64'(sb0.size()), 64'd0);
                return;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                ack0 = 1'b0;
                chk_reset0("midrst");
                @(negedge clk);
                chk("midrst_we_after", 64'(we0), 64'd0);
                chk("midrst_sb_empty", 64'(sb0.size()), 64'd0);
                return;
            end
            sb0.push_back('{e, dat0});
            @(negedge clk);
            ack0 = 1'b0;
        end
        chk("done_busy", 64'(busy0), 64'd1);
        chk("done_cyc", 64'(cyc0), 64'd0);
        req0 = hold;
        @(negedge clk);
        req0 = 1'b0;
        chk("idle_busy", 64'(busy0), 64'd0);
        @(negedge clk);
        chk("no_second_burst", 64'(busy0), 64'd0);
        chk("sb_empty", 64'(sb0.size()), 64'd0);
    endtask
    initial begin
        logic [31:0] e;
        repeat (3) @(negedge clk);
        chk_reset0("reset");
        chk("reset_busy1", 64'(busy1), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run(32'h0000_1008, 0, -1, -1, -1, 1'b0);
        run(32'h0000_2000, 2, 2, -1, -1, 1'b0);
        run(32'h0000_3010, 0, -1, 3, -1, 1'b0);
        run(32'h0000_3010, 0, -1, -1, -1, 1'b0);
        run(32'h0000_1000, 1, -1, -1, 4, 1'b0);
        run(32'h0000_5000, 0, -1, -1, -1, 1'b1);
        run(32'h0000_6014, 0, -1, -1, -1, 1'b0);
        req1 = 1'b1;
        adr1 = 32'h0000_4008;
        @(negedge clk);
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = 32'h0000_4000 | (((32'h2 + 32'(i)) & 32'h3) << 2);
            chk("c_cyc", 64'(cyc1), 64'd1);
            chk("c_adr", 64'(wbadr1), 64'(e));
            chk("c_cti", 64'(cti1), 64'd0);
            chk("c_bte", 64'(bte1), 64'd0);
            dat1 = mem(e);
            ack1 = 1'b1;
            sb1.push_back('{e, dat1});
            @(negedge clk);
            ack1 = 1'b0;
            if (i < 3) begin
                chk("c_wait_cyc", 64'(cyc1), 64'd0);
                chk("c_wait_busy", 64'(busy1), 64'd1);
                @(negedge clk);
            end
        end
        chk("c_done_busy", 64'(busy1), 64'd1);
        chk("c_done_cyc", 64'(cyc1), 64'd0);
        @(negedge clk);
        chk("c_idle_busy", 64'(busy1), 64'd0);
        @(negedge clk);
        chk("c_sb_empty", 64'(sb1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/icache_refill_wb.md
Name: icache_refill_wb

Overview:
- Refill engine on the memory side of the instruction cache refill interface.
- On a cache miss request it fetches one full cache line over a Wishbone B3 master port, critical word first with wrap-around inside the line.
- It streams each returned word back to the cache as a refill write (address, data, write strobe).
- It sits between the instruction cache and the instruction bus bridge and reports bus errors back to the cache.

Parameters:
- OPTION_OPERAND_WIDTH, 32, width of data and address buses.
- OPTION_ICACHE_BLOCK_WIDTH, 5, log2 of line size in bytes (5 = 8 words, 4 = 4 words); no other values are legal.
- BURST_ENABLE, 1, 1 = Wishbone incrementing wrap burst; 0 = one classic single read per word.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- refill_req_i  in  1  cache requests a line fill
- refill_adr_i  in  32  miss address; word-aligned, bits [1:0] ignored
- wradr_o  out  32  refill write address to cache
- wrdat_o  out  32  refill write data to cache
- we_o  out  1  refill write strobe, one cycle per word
- imem_err_o  out  1  one-cycle bus error pulse to cache
- busy_o  out  1  engine owns the bus (any state except IDLE)
- wbm_adr_o  out  32  bus address
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  bus strobe
- wbm_we_o  out  1  always 0
- wbm_sel_o  out  4  always 4'hf
- wbm_cti_o  out  3  cycle type identifier
- wbm_bte_o  out  2  burst type extension
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  bus acknowledge
- wbm_err_i  in  1  bus error
- wbm_rty_i  in  1  bus retry

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- Reset values: state IDLE; all outputs 0 except wbm_sel_o=4'hf. Reset mid-burst drops cyc/stb at the next edge, and no further we_o is issued.
- Line size: N = 2^(OPTION_ICACHE_BLOCK_WIDTH-2) words. The word index is refill_adr_i[BW-1:2] and the line base is refill_adr_i[31:BW], where BW = OPTION_ICACHE_BLOCK_WIDTH.
- FSM states: IDLE, BURST, WAIT (BURST_ENABLE=0 only), DONE.
- IDLE:
  - Trigger: refill_req_i=1 sampled at edge e.
  - Latch base, start word and the word pointer; clear the beat count.
  - Move to BURST. cyc/stb are high in the cycle after e (latency 1).
- BURST:
  - wbm_adr_o = {base, ptr, 2'b00}.
  - With BURST_ENABLE=1: cti=3'b010 and bte=2'b10 (N=8) or 2'b01 (N=4). cti=3'b111 when count==N-1.
  - With BURST_ENABLE=0: cti=3'b000, bte=2'b00.
- On wbm_ack_i:
  - Register wradr_o = current wbm_adr_o and wrdat_o = wbm_dat_i; we_o=1 for exactly the next cycle.
  - ptr = (ptr+1) mod N (wraps within the line); count+1.
  - If count==N-1, drop cyc/stb at the edge and go to DONE.
  - Else, if BURST_ENABLE=0, drop cyc/stb for one cycle via WAIT, then return to BURST.
  - Else keep cyc/stb high.
- wbm_rty_i without ack: hold stb, address and count unchanged; no write.
- wbm_err_i (takes priority over ack in the same cycle):
  - Drop cyc/stb at the edge; no we_o for that beat.
  - imem_err_o=1 for one cycle; go to IDLE.
  - A new refill_req_i is ignored in the cycle imem_err_o is high.
- DONE: lasts one cycle, covering the final we_o beat while the cache leaves its refill state. refill_req_i is ignored; go to IDLE.
- refill_req_i is ignored whenever busy_o=1; no queuing.
- wradr_o and wrdat_o hold their last value when we_o=0.
- Exactly N we_o pulses per successful refill, covering all N distinct word addresses of the line.

Test Plan:
- Miss at 0x0000_1008, N=8, ack every cycle:
  - Bus addresses 0x1008, 0x100C, …, 0x101C, then 0x1000, 0x1004.
  - cti = 010 for 7 beats, then 111; bte=10.
  - 8 we_o pulses, each one cycle after its ack, with matching wradr_o/wrdat_o.
  - busy_o falls 2 cycles after the last ack.
- Miss at 0x0000_2000 with ack every third cycle and rty on beat 3:
  - Address held through the retry; no duplicate or skipped we_o.
  - Total 8 writes, 0x2000–0x201C in order.
- wbm_err_i on beat 4 of a burst from 0x3010:
  - 3 we_o pulses only; imem_err_o a single pulse.
  - cyc low the next cycle; state IDLE; a new request one cycle later starts a fresh burst.
- BURST_ENABLE=0, BLOCK_WIDTH=4, miss at 0x4008:
  - Four classic reads at 0x4008, 0x400C, 0x4000, 0x4004; cti=000.
  - cyc low exactly one cycle between beats; 4 we_o pulses.
- rst asserted during beat 5 of a burst:
  - Next cycle all outputs at reset values; no we_o after reset.
  - A subsequent request at 0x5000 completes normally.
- refill_req_i held high through DONE:
  - No second burst starts.
  - A fresh request after one IDLE cycle starts a new burst.
